// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - writeback FIFO sequencing ALU/memory results onto the register file write port
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_dst,
  input  logic [DW-1:0] mem_data,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dst,
  input  logic [DW-1:0] alu_data,
  output logic          stall,
  output logic          RegWrite,
  output logic [AW-1:0] RegDst,
  output logic [DW-1:0] Mem_to_Reg,
  input  logic [AW-1:0] RA,
  input  logic [AW-1:0] RB,
  output logic          fwdA_hit,
  output logic [DW-1:0] fwdA_data,
  output logic          fwdB_hit,
  output logic [DW-1:0] fwdB_data,
  output logic          wb_idle,
  output logic          ovf_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [AW-1:0] q_dst  [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          mem_push;
  logic          alu_push;
  logic          accept_mem;
  logic          accept_alu;
  logic          pop;
  logic [PW-1:0] alu_slot;
  logic [CW-1:0] free_slots;

  // Push qualification: r0 writes vanish, and nothing is taken while producers are told to hold
  always_comb begin
    mem_push   = mem_valid && (mem_dst != '0);
    alu_push   = alu_valid && (alu_dst != '0);
    free_slots = CW'(DEPTH) - count;
    stall      = free_slots < CW'(2);
    accept_mem = mem_push && !stall;
    accept_alu = alu_push && !stall;
    pop        = (count != '0);
    // the ALU result lands behind the memory result when both arrive together
    alu_slot   = wr_ptr + PW'(accept_mem);
    wb_idle    = (count == '0) && !RegWrite;
  end

  // Entry storage; validity is tracked by the pointers, so the array needs no reset
  always_ff @(posedge clk) begin
    if (accept_mem) begin
      q_dst[wr_ptr]  <= mem_dst;
      q_data[wr_ptr] <= mem_data;
    end
    if (accept_alu) begin
      q_dst[alu_slot]  <= alu_dst;
      q_data[alu_slot] <= alu_data;
    end
  end

  // Pointer/count bookkeeping, head-to-write-port transfer and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      RegWrite   <= 1'b0;
      RegDst     <= '0;
      Mem_to_Reg <= '0;
      ovf_err    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(accept_mem) + PW'(accept_alu);
      count  <= count + CW'(accept_mem) + CW'(accept_alu) - CW'(pop);
      if (pop) begin
        RegWrite   <= 1'b1;
        RegDst     <= q_dst[rd_ptr];
        Mem_to_Reg <= q_data[rd_ptr];
        rd_ptr     <= rd_ptr + PW'(1);
      end else begin
        RegWrite <= 1'b0;
      end
      if (stall && (mem_push || alu_push)) begin
        ovf_err <= 1'b1;
      end
    end
  end

  // Forwarding search: output register first, then FIFO oldest to youngest so the youngest match overrides
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwdA_hit  = 1'b0;
    fwdA_data = '0;
    fwdB_hit  = 1'b0;
    fwdB_data = '0;
    if (RegWrite && (RegDst == RA)) begin
      fwdA_hit  = 1'b1;
      fwdA_data = Mem_to_Reg;
    end
    if (RegWrite && (RegDst == RB)) begin
      fwdB_hit  = 1'b1;
      fwdB_data = Mem_to_Reg;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        idx = rd_ptr + PW'(i);
        if (q_dst[idx] == RA) begin
          fwdA_hit  = 1'b1;
          fwdA_data = q_data[idx];
        end
        if (q_dst[idx] == RB) begin
          fwdB_hit  = 1'b1;
          fwdB_data = q_data[idx];
        end
      end
    end
    // r0 is hard-wired zero and must never be forwarded
    if (RA == '0) begin
      fwdA_hit  = 1'b0;
      fwdA_data = '0;
    end
    if (RB == '0) begin
      fwdB_hit  = 1'b0;
      fwdB_data = '0;
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - scoreboard bench for reg_writeback_queue
module tb_reg_writeback_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_valid;
  logic [2:0] mem_dst;
  logic [7:0] mem_data;
  logic       alu_valid;
  logic [2:0] alu_dst;
  logic [7:0] alu_data;
  logic       stall;
  logic       RegWrite;
  logic [2:0] RegDst;
  logic [7:0] Mem_to_Reg;
  logic [2:0] RA;
  logic [2:0] RB;
  logic       fwdA_hit;
  logic [7:0] fwdA_data;
  logic       fwdB_hit;
  logic [7:0] fwdB_data;
  logic       wb_idle;
  logic       ovf_err;

  int checks = 0;
  int errors = 0;

  logic [10:0] sb[$];
  logic [10:0] mon_exp;
  int          mcount  = 0;
  logic        rw_exp  = 1'b0;
  logic        ovf_exp = 1'b0;

  reg_writeback_queue #(.DEPTH(4), .AW(3), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
    .stall(stall), .RegWrite(RegWrite), .RegDst(RegDst), .Mem_to_Reg(Mem_to_Reg),
    .RA(RA), .RB(RB),
    .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data),
    .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data),
    .wb_idle(wb_idle), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Every issued write must match the oldest expected write in the scoreboard
  always @(negedge clk) begin
    if (!rst && RegWrite) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got r%0d=%02h required no write", RegDst, Mem_to_Reg);
      end else begin
        mon_exp = sb.pop_front();
        if ({RegDst, Mem_to_Reg} !== mon_exp) begin
          errors++;
          $display("FAIL write_order got r%0d=%02h required r%0d=%02h",
                   RegDst, Mem_to_Reg, mon_exp[10:8], mon_exp[7:0]);
        end
      end
    end
  end

  // One clock of stimulus, called at a negedge; checks the state-derived outputs first
  task automatic step(input logic mv, input logic [2:0] md, input logic [7:0] mdat,
                      input logic av, input logic [2:0] ad, input logic [7:0] adat);
    logic st;
    int   pushes;
    st = (4 - mcount) < 2;
    checks++;
    if (stall !== st) begin
      errors++;
      $display("FAIL stall got %b required %b", stall, st);
    end
    checks++;
    if (RegWrite !== rw_exp) begin
      errors++;
      $display("FAIL regwrite got %b required %b", RegWrite, rw_exp);
    end
    checks++;
    if (wb_idle !== ((mcount == 0) && !rw_exp)) begin
      errors++;
      $display("FAIL wb_idle got %b required %b", wb_idle, ((mcount == 0) && !rw_exp));
    end
    checks++;
    if (ovf_err !== ovf_exp) begin
      errors++;
      $display("FAIL ovf_err got %b required %b", ovf_err, ovf_exp);
    end
    mem_valid = mv; mem_dst = md; mem_data = mdat;
    alu_valid = av; alu_dst = ad; alu_data = adat;
    pushes = 0;
    if (!st) begin
      if (mv && md != 3'd0) begin sb.push_back({md, mdat}); pushes++; end
      if (av && ad != 3'd0) begin sb.push_back({ad, adat}); pushes++; end
    end else if ((mv && md != 3'd0) || (av && ad != 3'd0)) begin
      ovf_exp = 1'b1;
    end
    @(posedge clk);
    rw_exp = (mcount > 0);
    mcount = mcount - ((mcount > 0) ? 1 : 0) + pushes;
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_valid = 1'b0; mem_dst = 3'd0; mem_data = 8'h00;
    alu_valid = 1'b0; alu_dst = 3'd0; alu_data = 8'h00;
    RA = 3'd0; RB = 3'd0;
    #12;
    checks++;
    if ({RegWrite, RegDst, Mem_to_Reg, stall, ovf_err, wb_idle} !== {1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got rw=%b dst=%0d data=%02h stall=%b ovf=%b idle=%b required 0 0 00 0 0 1",
               RegWrite, RegDst, Mem_to_Reg, stall, ovf_err, wb_idle);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    RA = 3'd3;
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h5A);
    checks++;
    if ({fwdA_hit, fwdA_data} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL single_fwd got %b/%02h required 1/5a", fwdA_hit, fwdA_data);
    end
    idle(3);
  endtask

  task automatic test_both_valid;
    RA = 3'd2; RB = 3'd5;
    step(1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({fwdA_hit, fwdA_data} !== {1'b1, 8'h22}) begin
        errors++;
        $display("FAIL both_fwdA[%0d] got %b/%02h required 1/22", i, fwdA_hit, fwdA_data);
      end
      checks++;
      if ({fwdB_hit, fwdB_data} !== {1'b0, 8'h00}) begin
        errors++;
        $display("FAIL both_fwdB[%0d] got %b/%02h required 0/00", i, fwdB_hit, fwdB_data);
      end
      idle(1);
    end
    checks++;
    if ({fwdA_hit, fwdA_data} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL both_fwd_done got %b/%02h required 0/00", fwdA_hit, fwdA_data);
    end
    idle(1);
  endtask

  task automatic test_r0;
    RA = 3'd0;
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'hFF);
    checks++;
    if ({fwdA_hit, fwdA_data} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL r0_fwd got %b/%02h required 0/00", fwdA_hit, fwdA_data);
    end
    idle(2);
  endtask

  task automatic test_continuous;
    for (int i = 0; i < 20; i++)
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'((i % 7) + 1), 8'(i * 3 + 1));
    idle(3);
  endtask

  task automatic test_overflow;
    RA = 3'd6; RB = 3'd4;
    step(1'b1, 3'd1, 8'hA1, 1'b1, 3'd2, 8'hA2);
    step(1'b1, 3'd3, 8'hA3, 1'b1, 3'd4, 8'hA4);
    checks++;
    if ({fwdB_hit, fwdB_data} !== {1'b1, 8'hA4}) begin
      errors++;
      $display("FAIL ovf_fwdB got %b/%02h required 1/a4", fwdB_hit, fwdB_data);
    end
    step(1'b1, 3'd5, 8'hA5, 1'b1, 3'd6, 8'hA6);
    checks++;
    if (fwdA_hit !== 1'b0) begin
      errors++;
      $display("FAIL ovf_dropped_fwd got %b required 0", fwdA_hit);
    end
    idle(5);
  endtask

  task automatic test_reset_mid_burst;
    RA = 3'd6;
    step(1'b1, 3'd4, 8'hB4, 1'b1, 3'd5, 8'hB5);
    step(1'b1, 3'd6, 8'hB6, 1'b1, 3'd7, 8'hB7);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({RegWrite, wb_idle, stall, ovf_err, fwdA_hit} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_mid_burst got rw=%b idle=%b stall=%b ovf=%b hit=%b required 0 1 0 0 0",
               RegWrite, wb_idle, stall, ovf_err, fwdA_hit);
    end
    sb.delete();
    mcount = 0; rw_exp = 1'b0; ovf_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_valid();
    test_r0();
    test_continuous();
    test_overflow();
    test_reset_mid_burst();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
